blake2_host_drv: RTL and testbench

Host-side driver for the Blake2 accelerator pin protocol on the FPGA emulator build. It frames a message from a local byte stream into the accelerator's 8-bit data pins and 3-bit control pins: a 3-byte configuration header, the data bytes, and a LAST marker on the final byte. It then captures the returned hash bytes and forwards them as a local stream. It sits in the same clock domain as the accelerator top and drives the inputs that the emulator otherwise takes from PMOD headers.

---
 rtl/blake2_host_drv.sv | 219 +++++++++++++++++++++
 tb/tb_blake2_host_drv.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/blake2_host_drv.sv
// Host-side framer for the Blake2 accelerator pin protocol: sends config
// header and message bytes through a one-deep pin stage, then collects the hash.
module blake2_host_drv #(
    parameter int unsigned HASH_BYTES     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] msg_len_i,
    input  logic        msg_valid_i,
    input  logic [7:0]  msg_data_i,
    output logic        msg_ready_o,
    output logic        hash_valid_o,
    output logic [7:0]  hash_data_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [7:0]  ui_in_o,
    output logic [2:0]  uio_in_o,
    input  logic [7:0]  uio_out_i,
    input  logic [7:0]  uo_out_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);
    localparam logic [6:0]    HB_CNT  = 7'(HASH_BYTES);
    localparam logic [7:0]    HB_BYTE = 8'(HASH_BYTES);

    localparam logic [1:0] CMD_CFG  = 2'b00;
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_LAST = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_DATA,
        S_WAIT,
        S_RX
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [1:0]    cfg_idx_q, cfg_idx_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic [6:0]    hash_cnt_q, hash_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          pin_vld_q, pin_vld_d;
    logic [7:0]    pin_data_q, pin_data_d;
    logic [1:0]    pin_cmd_q, pin_cmd_d;
    logic          hash_valid_q, hash_valid_d;
    logic [7:0]    hash_data_q, hash_data_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;

    logic acc_ready;
    logic acc_hv;
    logic xfer;
    logic slot_free;
    logic msg_take;

    assign acc_ready = uio_out_i[7];
    assign acc_hv    = uio_out_i[3];
    assign xfer      = pin_vld_q && acc_ready;
    // The pin register can take a new byte when empty or emptying this cycle.
    assign slot_free = !pin_vld_q || xfer;

    assign msg_ready_o = (state_q == S_DATA) && slot_free
                         && (byte_cnt_q < len_q);
    assign msg_take    = msg_ready_o && msg_valid_i;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cfg_idx_d    = cfg_idx_q;
        byte_cnt_d   = byte_cnt_q;
        hash_cnt_d   = hash_cnt_q;
        to_cnt_d     = to_cnt_q;
        pin_vld_d    = pin_vld_q;
        pin_data_d   = pin_data_q;
        pin_cmd_d    = pin_cmd_q;
        hash_valid_d = 1'b0;
        hash_data_d  = hash_data_q;
        done_d       = 1'b0;
        timeout_d    = timeout_q;

        if (xfer) begin
            pin_vld_d  = 1'b0;
            pin_data_d = 8'd0;
            pin_cmd_d  = CMD_CFG;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d      = msg_len_i;
                    timeout_d  = 1'b0;
                    byte_cnt_d = 16'd0;
                    hash_cnt_d = 7'd0;
                    cfg_idx_d  = 2'd1;
                    pin_vld_d  = 1'b1;
                    pin_data_d = HB_BYTE;
                    pin_cmd_d  = CMD_CFG;
                    state_d    = S_CFG;
                end
            end

            S_CFG: begin
                if (cfg_idx_q != 2'd3) begin
                    if (slot_free) begin
                        pin_vld_d  = 1'b1;
                        pin_data_d = (cfg_idx_q == 2'd1) ? len_q[7:0]
                                                         : len_q[15:8];
                        pin_cmd_d  = CMD_CFG;
                        cfg_idx_d  = cfg_idx_q + 2'd1;
                        // Enter DATA early so message bytes follow back-to-back.
                        if (cfg_idx_q == 2'd2 && len_q != 16'd0) begin
                            state_d = S_DATA;
                        end
                    end
                end else if (xfer) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT;
                end
            end

            S_DATA: begin
                if (msg_take) begin
                    pin_vld_d  = 1'b1;
                    pin_data_d = msg_data_i;
                    pin_cmd_d  = (byte_cnt_q == len_q - 16'd1) ? CMD_LAST
                                                               : CMD_DATA;
                    byte_cnt_d = byte_cnt_q + 16'd1;
                end
                if (xfer && pin_cmd_q == CMD_LAST) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT;
                end
            end

            S_WAIT: begin
                if (acc_hv) begin
                    hash_valid_d = 1'b1;
                    hash_data_d  = uo_out_i;
                    hash_cnt_d   = 7'd1;
                    if (HB_CNT == 7'd1) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RX;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end

            S_RX: begin
                if (acc_hv) begin
                    hash_valid_d = 1'b1;
                    hash_data_d  = uo_out_i;
                    hash_cnt_d   = hash_cnt_q + 7'd1;
                    if (hash_cnt_q + 7'd1 == HB_CNT) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            cfg_idx_q    <= 2'd0;
            byte_cnt_q   <= 16'd0;
            hash_cnt_q   <= 7'd0;
            to_cnt_q     <= '0;
            pin_vld_q    <= 1'b0;
            pin_data_q   <= 8'd0;
            pin_cmd_q    <= CMD_CFG;
            hash_valid_q <= 1'b0;
            hash_data_q  <= 8'd0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cfg_idx_q    <= cfg_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            hash_cnt_q   <= hash_cnt_d;
            to_cnt_q     <= to_cnt_d;
            pin_vld_q    <= pin_vld_d;
            pin_data_q   <= pin_data_d;
            pin_cmd_q    <= pin_cmd_d;
            hash_valid_q <= hash_valid_d;
            hash_data_q  <= hash_data_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign hash_valid_o = hash_valid_q;
    assign hash_data_o  = hash_data_q;
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;
    assign ui_in_o      = pin_data_q;
    assign uio_in_o     = {pin_cmd_q, pin_vld_q};

endmodule

// File: tb/tb_blake2_host_drv.sv
// Randomized bench for blake2_host_drv with a frame/hash reference model
// and a simple accelerator pin model.
module tb_blake2_host_drv;

    localparam int HB = 32;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] msg_len_i = 16'd0;
    logic        msg_valid_i = 1'b0;
    logic [7:0]  msg_data_i = 8'd0;
    logic        msg_ready_o;
    logic        hash_valid_o;
    logic [7:0]  hash_data_o;
    logic        done_o;
    logic        busy_o;
    logic        timeout_o;
    logic [7:0]  ui_in_o;
    logic [2:0]  uio_in_o;
    logic [7:0]  uio_out_i = 8'd0;
    logic [7:0]  uo_out_i = 8'd0;

    int n_chk = 0;
    int n_fail = 0;

    blake2_host_drv #(
        .HASH_BYTES(HB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_i(start_i),
        .msg_len_i(msg_len_i),
        .msg_valid_i(msg_valid_i),
        .msg_data_i(msg_data_i),
        .msg_ready_o(msg_ready_o),
        .hash_valid_o(hash_valid_o),
        .hash_data_o(hash_data_o),
        .done_o(done_o),
        .busy_o(busy_o),
        .timeout_o(timeout_o),
        .ui_in_o(ui_in_o),
        .uio_in_o(uio_in_o),
        .uio_out_i(uio_out_i),
        .uo_out_i(uo_out_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random
    task automatic run_txn(input int len, input int rmode, input bit vrand,
                           input bit respond, input bit abc);
        logic [10:0] exp_pins[$];
        logic [7:0]  msg[$];
        logic [7:0]  hq[$];
        int          hcyc[$];
        logic [15:0] l16;
        logic [10:0] held;
        logic [7:0]  hb;
        bit          hold, finished, rdy, hv, timing;
        int          tx, midx, hdrv, hpulse, last_tx_cyc;

        l16 = 16'(len);
        timing = (rmode == 0) && !vrand;
        for (int i = 0; i < len; i++) begin
            if (abc) msg.push_back(8'(8'h61 + i));
            else msg.push_back(8'($urandom));
        end
        exp_pins.push_back({8'(HB), 3'b001});
        exp_pins.push_back({l16[7:0], 3'b001});
        exp_pins.push_back({l16[15:8], 3'b001});
        for (int i = 0; i < len; i++)
            exp_pins.push_back({msg[i], (i == len - 1) ? 3'b101 : 3'b011});

        hold = 0; finished = 0; held = '0;
        tx = 0; midx = 0; hdrv = 0; hpulse = 0; last_tx_cyc = -1;

        @(negedge clk);
        start_i = 1'b1;
        msg_len_i = l16;
        msg_valid_i = 1'b0;
        uio_out_i = 8'd0;

        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            @(negedge clk);
            start_i = busy_o && ($urandom % 8 == 0);
            msg_len_i = 16'($urandom);
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = ((cyc - 1) % 3 == 0);
                default: rdy = 1'($urandom % 2);
            endcase
            msg_valid_i = vrand ? 1'($urandom % 2) : 1'b1;
            msg_data_i = (midx < len) ? msg[midx] : 8'($urandom);
            hb = 8'($urandom);
            hv = 1'b0;
            if (last_tx_cyc < 0) begin
                hv = 1'($urandom % 2);
            end else if (respond && cyc > last_tx_cyc && hdrv < HB) begin
                hv = (hdrv == 0) || (rmode == 0) || ($urandom % 2 == 0);
                if (hv) begin
                    hq.push_back(hb);
                    hcyc.push_back(cyc);
                    hdrv++;
                end
            end
            uo_out_i = hb;
            uio_out_i = {rdy, 3'b000, hv, 3'b000};
            #1;

            if (cyc == 1) begin
                check_eq("busy_c1", busy_o, 1);
                check_eq("timeout_clr", timeout_o, 0);
            end
            if (hold) check_eq("pin_hold", {ui_in_o, uio_in_o}, held);
            if (uio_in_o[0] && rdy) begin
                if (tx < exp_pins.size()) begin
                    check_eq("pin_byte", {ui_in_o, uio_in_o}, exp_pins[tx]);
                    if (timing) check_eq("pin_cycle", cyc, tx + 1);
                end else begin
                    check_eq("extra_xfer", tx, exp_pins.size() - 1);
                end
                tx++;
                if (tx == exp_pins.size()) last_tx_cyc = cyc;
            end
            hold = uio_in_o[0] && !rdy;
            held = {ui_in_o, uio_in_o};
            if (msg_valid_i && msg_ready_o) begin
                check_eq("msg_overrun", midx < len, 1);
                midx++;
            end
            if (hash_valid_o) begin
                if (hq.size() == 0) begin
                    check_eq("hash_extra", hpulse, HB);
                end else begin
                    check_eq("hash_byte", hash_data_o, hq.pop_front());
                    check_eq("hash_lag", cyc, hcyc.pop_front() + 1);
                end
                hpulse++;
                check_eq("done_pulse", done_o, hpulse == HB);
            end else if (done_o) begin
                check_eq("done_no_hv", done_o, 0);
            end
            if (done_o) begin
                check_eq("busy_at_done", busy_o, 0);
                finished = 1;
            end
            if (timeout_o) begin
                check_eq("timeout_flag", timeout_o, !respond);
                check_eq("timeout_cycle", cyc, last_tx_cyc + 1 + TO);
                check_eq("busy_at_to", busy_o, 0);
                check_eq("done_at_to", done_o, 0);
                finished = 1;
            end
        end
        check_eq("txn_finish", finished, 1);
        check_eq("xfer_count", tx, exp_pins.size());
        check_eq("msg_consumed", midx, len);
        if (respond) check_eq("hash_count", hpulse, HB);
        start_i = 1'b0;
        msg_valid_i = 1'b0;
        uio_out_i = 8'd0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ui", ui_in_o, 0);
        check_eq("rst_uio", uio_in_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_mready", msg_ready_o, 0);
        check_eq("rst_hv", hash_valid_o, 0);
        check_eq("rst_hdata", hash_data_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_to", timeout_o, 0);
        reset = 1'b0;
        uio_out_i = 8'h80;
        repeat (10) begin
            @(negedge clk);
            #1;
            check_eq("idle_pins", {ui_in_o, uio_in_o}, 0);
            check_eq("idle_busy", busy_o, 0);
        end
        uio_out_i = 8'd0;

        run_txn(3, 0, 0, 1, 1);
        run_txn(3, 1, 0, 1, 1);
        run_txn(0, 0, 0, 0, 0);
        run_txn(0, 0, 0, 1, 0);

        // Reset during DATA after two message bytes
        @(negedge clk);
        start_i = 1'b1;
        msg_len_i = 16'd5;
        uio_out_i = 8'h80;
        msg_valid_i = 1'b1;
        msg_data_i = 8'($urandom);
        repeat (5) begin
            @(negedge clk);
            start_i = 1'b0;
            msg_data_i = 8'($urandom);
        end
        #1;
        check_eq("mid_data_cmd", uio_in_o, 3'b011);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_eq("mid_rst_pins", {ui_in_o, uio_in_o}, 0);
        check_eq("mid_rst_busy", busy_o, 0);
        check_eq("mid_rst_mready", msg_ready_o, 0);
        reset = 1'b0;
        msg_valid_i = 1'b0;
        uio_out_i = 8'd0;
        run_txn(5, 0, 0, 1, 0);

        for (int k = 0; k < 8; k++)
            run_txn($urandom_range(1, 40), 2, 1, (k % 4) != 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
